// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, one full-subtractor cell stepped LSB-first
// over WIDTH clocks, with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, dsh_reg, d_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg, bout_reg, v_reg;
  logic             accept, last;

  logic             a0, b0, d_bit, br_next;
  logic [WIDTH-1:0] a_shr, b_shr, d_shr;

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign a0      = a_reg[0];
  assign b0      = b_reg[0];
  assign d_bit   = a0 ^ b0 ^ br_reg;
  assign br_next = (~a0 & b0) | (~a0 & br_reg) | (b0 & br_reg);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_shr[gi] = a_reg[gi+1];
      assign b_shr[gi] = b_reg[gi+1];
      assign d_shr[gi] = dsh_reg[gi+1];
    end
  endgenerate
  assign a_shr[WIDTH-1] = 1'b0;
  assign b_shr[WIDTH-1] = 1'b0;
  assign d_shr[WIDTH-1] = d_bit;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      dsh_reg  <= '0;
      d_reg    <= '0;
      cnt_reg  <= '0;
      br_reg   <= 1'b0;
      bout_reg <= 1'b0;
      v_reg    <= 1'b0;
    end else if (accept) begin
      a_reg   <= A;
      b_reg   <= B;
      br_reg  <= Bin;
      cnt_reg <= '0;
    end else if (state_reg == RUN) begin
      a_reg   <= a_shr;
      b_reg   <= b_shr;
      dsh_reg <= d_shr;
      br_reg  <= br_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (last) begin
        d_reg    <= d_shr;
        bout_reg <= br_next;
        // Signed overflow: borrow into the MSB differs from borrow out of it.
        v_reg    <= br_reg ^ br_next;
      end
    end
  end

  assign D    = d_reg;
  assign Bout = bout_reg;
  assign V    = v_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=8 and WIDTH=4.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, v8;
  logic [7:0] a8, b8, d8;
  logic       in_valid4, in_ready4, bin4, out_valid4, out_ready4, bout4, v4;
  logic [3:0] a4, b4, d4;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .Bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .D(d8), .Bout(bout8), .V(v8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .Bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .D(d4), .Bout(bout4), .V(v4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input logic ev, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready8, 1);
    a8 = a; b8 = b; bin8 = bin; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    a8 = 8'hC3; b8 = 8'h5A; bin8 = ~bin;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_D"}, d8, ed);
    check({tag, "_Bout"}, bout8, eb);
    check({tag, "_V"}, v8, ev);
    $display("op8 %s: A=%02h B=%02h Bin=%0d -> D=%02h Bout=%0d V=%0d lat=%0d",
             tag, a, b, bin, d8, bout8, v8, lat);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
    check({tag, "_idle_ready"}, in_ready8, 1);
    check({tag, "_idle_valid"}, out_valid8, 0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int lat, diff, sa, sb, sr, stall;
    logic [3:0] ed;
    logic eb, ev;
    diff = int'(a) - int'(b) - int'(bin);
    ed = diff[3:0];
    eb = (diff < 0);
    sa = (a >= 8) ? int'(a) - 16 : int'(a);
    sb = (b >= 8) ? int'(b) - 16 : int'(b);
    sr = sa - sb - int'(bin);
    ev = (sr < -8) || (sr > 7);
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bin; in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    stall = $urandom_range(0, 3);
    repeat (stall) @(posedge clk);
    #1;
    check("w4_result", {lat[7:0], 1'b0, eb, ev, ed},
          {8'd4, 1'b0, eb, ev, ed} ^ {lat[7:0] ^ 8'd4, 1'b0, bout4 ^ eb, v4 ^ ev, d4 ^ ed});
    $display("op4: A=%0h B=%0h Bin=%0d -> D=%0h Bout=%0d V=%0d lat=%0d stall=%0d",
             a, b, bin, d4, bout4, v4, lat, stall);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1 out_ready4 = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    in_valid8 = 0; bin8 = 0; a8 = 0; b8 = 0; out_ready8 = 0;
    in_valid4 = 0; bin4 = 0; a4 = 0; b4 = 0; out_ready4 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready8, 1);
    check("rst_out_valid", out_valid8, 0);
    check("rst_D", d8, 0);
    check("rst_Bout", bout8, 0);
    check("rst_V", v8, 0);
    rst = 1'b0;

    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "basic");
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "wrap");
    op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "bin_chain");
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "ovf_neg");
    op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "ovf_pos");

    // Backpressure with stray operands offered during RUN and DONE.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 0; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_run_in_ready", in_ready8, 0);
      a8 = 8'hAA; b8 = 8'h01; in_valid8 = (i % 2 == 0);
    end
    @(negedge clk) in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check("bp_out_valid", out_valid8, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_D", d8, 8'h22);
      check("bp_hold_BV", {bout8, v8}, 2'b00);
      check("bp_hold_in_ready", in_ready8, 0);
      in_valid8 = i[0]; a8 = 8'($urandom);
    end
    $display("backpressure: D=%02h held for 20 cycles", d8);
    @(negedge clk);
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
    check("bp_ready_after", in_ready8, 1);
    repeat (3) begin
      @(negedge clk);
      check("bp_not_consumed_valid", out_valid8, 0);
      check("bp_not_consumed_D", d8, 8'h22);
    end

    // Reset in the middle of a run.
    @(negedge clk);
    a8 = 8'h44; b8 = 8'h11; bin8 = 0; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_in_ready", in_ready8, 1);
    check("midrst_out_valid", out_valid8, 0);
    check("midrst_D", d8, 0);
    $display("mid-op reset: in_ready=%0d out_valid=%0d D=%02h", in_ready8, out_valid8, d8);
    op8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, "after_rst");

    for (int i = 0; i < 512; i++) begin
      op4(4'(i >> 5), 4'(i >> 1), i[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
